// File: rtl/operand_fetch.sv
// operand_fetch: scoreboarded operand fetch stage with writeback bypass and a one-entry output register
module operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [4:0]  instr_rs,
    input  logic [4:0]  instr_rt,
    input  logic [4:0]  instr_rd,
    input  logic        instr_writes,
    output logic [4:0]  read_register1,
    output logic [4:0]  read_register2,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_writes,
    output logic [15:0] stall_count
);
    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        hit_rs;
    logic        hit_rt;
    logic        hit_rd;
    logic        src_haz;
    logic        dst_haz;
    logic        issue;
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign read_register1 = instr_rs;
    assign read_register2 = instr_rt;

    // Hazard detection, with a same-cycle writeback counting as already resolved
    always_comb begin
        hit_rs      = wb_valid && wb_reg == instr_rs && instr_rs != 5'd0;
        hit_rt      = wb_valid && wb_reg == instr_rt && instr_rt != 5'd0;
        hit_rd      = wb_valid && wb_reg == instr_rd && instr_rd != 5'd0;
        src_haz     = (busy[instr_rs] && !hit_rs) || (busy[instr_rt] && !hit_rt);
        dst_haz     = instr_writes && busy[instr_rd] && !hit_rd;
        instr_ready = !src_haz && !dst_haz && (!out_valid || out_ready) && !rst;
        issue       = instr_valid && instr_ready;
        op_a        = instr_rs == 5'd0 ? 32'd0 : hit_rs ? wb_data : read_data1;
        op_b        = instr_rt == 5'd0 ? 32'd0 : hit_rt ? wb_data : read_data2;
    end

    // Scoreboard update: writeback clears first so a same-edge issue set wins; r0 never busy
    always_comb begin
        busy_next = busy;
        if (wb_valid)
            busy_next[wb_reg] = 1'b0;
        if (issue && instr_writes)
            busy_next[instr_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // State registers: scoreboard, output bundle and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 32'd0;
            out_valid   <= 1'b0;
            out_a       <= 32'd0;
            out_b       <= 32'd0;
            out_rd      <= 5'd0;
            out_writes  <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            busy <= busy_next;
            if (issue) begin
                out_valid  <= 1'b1;
                out_a      <= op_a;
                out_b      <= op_b;
                out_rd     <= instr_rd;
                out_writes <= instr_writes;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (instr_valid && (src_haz || dst_haz) && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed self-checking bench for operand_fetch
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  instr_rs;
    logic [4:0]  instr_rt;
    logic [4:0]  instr_rd;
    logic        instr_writes;
    logic [4:0]  read_register1;
    logic [4:0]  read_register2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_writes;
    logic [15:0] stall_count;
    int total = 0;
    int bad = 0;

    operand_fetch dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd), .instr_writes(instr_writes),
        .read_register1(read_register1), .read_register2(read_register2),
        .read_data1(read_data1), .read_data2(read_data2),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_writes(out_writes), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic w, input logic [31:0] d1, input logic [31:0] d2);
        instr_valid = v; instr_rs = rs; instr_rt = rt; instr_rd = rd; instr_writes = w;
        read_data1 = d1; read_data2 = d2;
        #1;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        drive(1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 32'd0, 32'd0);
        chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
        tick; tick;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);
        chk("rst_busy", dut.busy, 32'd0);
        rst = 1'b0;
        // basic issue
        drive(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 32'd42, 32'd15);
        chk("rr1", {27'd0, read_register1}, 32'd2);
        chk("rr2", {27'd0, read_register2}, 32'd3);
        chk("ready_basic", {31'd0, instr_ready}, 32'd1);
        tick;
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_a", out_a, 32'd42);
        chk("basic_b", out_b, 32'd15);
        chk("basic_rd", {27'd0, out_rd}, 32'd4);
        chk("basic_w", {31'd0, out_writes}, 32'd1);
        chk("basic_busy4", {31'd0, dut.busy[4]}, 32'd1);
        // RAW stall then bypass
        drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 32'd999, 32'd0);
        chk("raw_ready", {31'd0, instr_ready}, 32'd0);
        tick;
        chk("raw_stall1", {16'd0, stall_count}, 32'd1);
        chk("raw_drained", {31'd0, out_valid}, 32'd0);
        tick;
        chk("raw_stall2", {16'd0, stall_count}, 32'd2);
        wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'd26; #1;
        chk("bypass_ready", {31'd0, instr_ready}, 32'd1);
        tick;
        chk("bypass_a", out_a, 32'd26);
        chk("bypass_valid", {31'd0, out_valid}, 32'd1);
        chk("bypass_busy4", {31'd0, dut.busy[4]}, 32'd0);
        chk("bypass_stall", {16'd0, stall_count}, 32'd2);
        // r0 reads and writeback to r0
        wb_reg = 5'd0; wb_data = 32'd59;
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'd77, 32'd88);
        chk("r0_ready", {31'd0, instr_ready}, 32'd1);
        tick;
        chk("r0_a", out_a, 32'd0);
        chk("r0_b", out_b, 32'd0);
        chk("r0_busy", dut.busy, 32'd0);
        // backpressure
        wb_valid = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'd100, 32'd200);
        tick;
        chk("bp_first_a", out_a, 32'd100);
        out_ready = 1'b0;
        drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 32'd300, 32'd400);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", {31'd0, instr_ready}, 32'd0);
            tick;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_a", out_a, 32'd100);
            chk("bp_hold_b", out_b, 32'd200);
            chk("bp_stall", {16'd0, stall_count}, 32'd2);
        end
        out_ready = 1'b1; #1;
        chk("bp_release_ready", {31'd0, instr_ready}, 32'd1);
        tick;
        chk("bp_next_a", out_a, 32'd300);
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        // set beats clear, then WAW
        drive(1'b1, 5'd0, 5'd0, 5'd17, 1'b1, 32'd0, 32'd0);
        tick;
        chk("waw_busy_a", {31'd0, dut.busy[17]}, 32'd1);
        wb_valid = 1'b1; wb_reg = 5'd17; wb_data = 32'd5; #1;
        chk("setclr_ready", {31'd0, instr_ready}, 32'd1);
        tick;
        chk("setclr_busy", {31'd0, dut.busy[17]}, 32'd1);
        wb_valid = 1'b0; #1;
        chk("waw_ready", {31'd0, instr_ready}, 32'd0);
        tick;
        chk("waw_stall", {16'd0, stall_count}, 32'd3);
        wb_valid = 1'b1; #1;
        chk("waw_release", {31'd0, instr_ready}, 32'd1);
        tick;
        chk("waw_out_rd", {27'd0, out_rd}, 32'd17);
        chk("waw_busy_b", {31'd0, dut.busy[17]}, 32'd1);
        // reset with pending state
        wb_valid = 1'b0;
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 32'd0, 32'd0);
        tick;
        chk("pre_rst_busy5", {31'd0, dut.busy[5]}, 32'd1);
        rst = 1'b1;
        drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 32'd55, 32'd0);
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        tick;
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_a", out_a, 32'd0);
        chk("rst2_rd", {27'd0, out_rd}, 32'd0);
        chk("rst2_w", {31'd0, out_writes}, 32'd0);
        chk("rst2_stall", {16'd0, stall_count}, 32'd0);
        chk("rst2_busy", dut.busy, 32'd0);
        rst = 1'b0; #1;
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        tick;
        chk("post_rst_a", out_a, 32'd55);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
